// File: rtl/rom_load_ctrl_pkg.sv
// rom_load_ctrl_pkg: shared definitions for the ROM download controller.
// Holds the controller state encoding, the hps_io download index codes and
// the game-select byte codes written during a MOD download.
package rom_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM,
        ST_MOD,
        ST_DIP,
        ST_SKIP,
        ST_SETTLE
    } state_t;

    // hps_io download index values
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Game-select byte written at address 0 of a MOD download
    localparam logic [7:0] MOD_BWIDOW   = 8'd0;
    localparam logic [7:0] MOD_GRAVITAR = 8'd1;
    localparam logic [7:0] MOD_LUNARBAT = 8'd2;
    localparam logic [7:0] MOD_SPACDUEL = 8'd3;

    // State a new download enters, chosen by its index
    function automatic state_t index_target(input logic [7:0] idx);
        state_t st;
        case (idx)
            IDX_ROM: st = ST_ROM;
            IDX_MOD: st = ST_MOD;
            IDX_DIP: st = ST_DIP;
            default: st = ST_SKIP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: routes the hps_io download bus to the game core.
//   index 0   -> ROM image, forwarded to the core ROM write port
//   index 1   -> game select byte (one-hot mod_* outputs)
//   index 254 -> DIP switch bytes 0..2
//   others    -> ignored
// After a ROM download the core is held in reset for SETTLE_CYCLES clocks.
// Ports:
//   clk_12, reset            : clock, asynchronous active-high reset
//   ioctl_*                  : hps_io download bus (inputs)
//   dn_addr/dn_data/dn_wr    : core ROM write port, one clock after ioctl write
//   mod_*                    : one-hot game select
//   dip0..dip2               : DIP bytes
//   core_reset_hold          : keeps the game core in reset
//   load_done/load_err       : ROM load status; rom_bytes: accepted ROM bytes
module rom_load_ctrl
    import rom_load_ctrl_pkg::*;
#(
    parameter int ROM_BYTES     = 65536,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk_12,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        mod_bwidow,
    output logic        mod_gravitar,
    output logic        mod_lunarbat,
    output logic        mod_spacduel,
    output logic [7:0]  dip0,
    output logic [7:0]  dip1,
    output logic [7:0]  dip2,
    output logic        core_reset_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [16:0] rom_bytes
);

    localparam int          CNT_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [24:0] ROM_LIMIT = 25'(ROM_BYTES);

    state_t           state, state_next, dl_target, wr_state;
    logic             dl_prev, dl_armed, dl_rise, dl_fall;
    logic [CNT_W-1:0] cnt;
    logic             settle_done, rom_entry;
    logic             rom_wr_ok, rom_wr_bad, mod_wr, dip_wr;
    logic             boot_hold;
    logic [3:0]       mod_sel;   // {bwidow, gravitar, lunarbat, spacduel}

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // dl_armed blocks a download that was already high when reset released
        dl_rise     = ioctl_download & ~dl_prev & dl_armed;
        dl_fall     = ~ioctl_download & dl_prev;
        dl_target   = index_target(ioctl_index);
        state_next  = state;
        settle_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dl_rise) state_next = dl_target;
            end
            ST_ROM: begin
                if (dl_fall) state_next = ST_SETTLE;
            end
            ST_MOD, ST_DIP, ST_SKIP: begin
                if (dl_fall) state_next = ST_IDLE;
            end
            ST_SETTLE: begin
                if (dl_rise) begin
                    state_next = dl_target;
                end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_next  = ST_IDLE;
                    settle_done = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        rom_entry = (state_next == ST_ROM) && (state != ST_ROM);

        // On the rising-edge cycle the state register still lags, so writes
        // are routed by the incoming index instead.
        wr_state   = dl_rise ? dl_target : state;
        rom_wr_ok  = ioctl_wr && (wr_state == ST_ROM) && (ioctl_addr <  ROM_LIMIT);
        rom_wr_bad = ioctl_wr && (wr_state == ST_ROM) && (ioctl_addr >= ROM_LIMIT);
        mod_wr     = ioctl_wr && (wr_state == ST_MOD) && (ioctl_addr == 25'd0);
        dip_wr     = ioctl_wr && (wr_state == ST_DIP);

        core_reset_hold = boot_hold || (state == ST_ROM) || (state == ST_SETTLE);
    end

    assign mod_bwidow   = mod_sel[3];
    assign mod_gravitar = mod_sel[2];
    assign mod_lunarbat = mod_sel[1];
    assign mod_spacduel = mod_sel[0];

    always_ff @(posedge clk_12 or posedge reset) begin
        if (reset) begin
            dl_prev   <= 1'b0;
            dl_armed  <= 1'b0;
            cnt       <= '0;
            dn_wr     <= 1'b0;
            dn_addr   <= 16'd0;
            dn_data   <= 8'd0;
            rom_bytes <= 17'd0;
            load_err  <= 1'b0;
            load_done <= 1'b0;
            boot_hold <= 1'b1;
            mod_sel   <= 4'b1000;
            dip0      <= 8'h00;
            dip1      <= 8'h00;
            dip2      <= 8'h00;
        end else begin
            dl_prev <= ioctl_download;
            if (!ioctl_download) dl_armed <= 1'b1;

            // Free-runs only while settling; any exit (done or abort) rewinds it
            cnt <= (state == ST_SETTLE) ? cnt + 1'b1 : '0;

            dn_wr <= rom_wr_ok;
            if (rom_wr_ok) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end

            // A write on the entry cycle counts as the first byte of the image
            if (rom_entry) begin
                rom_bytes <= rom_wr_ok ? 17'd1 : 17'd0;
            end else if (rom_wr_ok && rom_bytes != 17'h1FFFF) begin
                rom_bytes <= rom_bytes + 17'd1;
            end

            if (rom_entry) load_done <= 1'b0;
            else if (settle_done) load_done <= 1'b1;
            if (settle_done) boot_hold <= 1'b0;

            if (mod_wr) begin
                case (ioctl_dout)
                    MOD_BWIDOW:   mod_sel <= 4'b1000;
                    MOD_GRAVITAR: mod_sel <= 4'b0100;
                    MOD_LUNARBAT: mod_sel <= 4'b0010;
                    MOD_SPACDUEL: mod_sel <= 4'b0001;
                    default:      mod_sel <= 4'b1000;
                endcase
            end

            // Set has priority so an error on the entry cycle is not lost
            if (rom_wr_bad || (mod_wr && ioctl_dout > MOD_SPACDUEL)) begin
                load_err <= 1'b1;
            end else if (rom_entry) begin
                load_err <= 1'b0;
            end

            if (dip_wr) begin
                case (ioctl_addr)
                    25'd0:   dip0 <= ioctl_dout;
                    25'd1:   dip1 <= ioctl_dout;
                    25'd2:   dip2 <= ioctl_dout;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: self-checking bench for rom_load_ctrl.
// ROM writes push their expected core write into a queue; a monitor pops
// and compares each dn_wr pulse, including its one-clock latency.
module tb_rom_load_ctrl;

    localparam int TB_ROM_BYTES = 16;
    localparam int TB_SETTLE    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        mod_bwidow, mod_gravitar, mod_lunarbat, mod_spacduel;
    logic [7:0]  dip0, dip1, dip2;
    logic        core_reset_hold, load_done, load_err;
    logic [16:0] rom_bytes;

    rom_load_ctrl #(
        .ROM_BYTES     (TB_ROM_BYTES),
        .SETTLE_CYCLES (TB_SETTLE)
    ) dut (
        .clk_12          (clk),
        .reset           (reset),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .ioctl_index     (ioctl_index),
        .dn_addr         (dn_addr),
        .dn_data         (dn_data),
        .dn_wr           (dn_wr),
        .mod_bwidow      (mod_bwidow),
        .mod_gravitar    (mod_gravitar),
        .mod_lunarbat    (mod_lunarbat),
        .mod_spacduel    (mod_spacduel),
        .dip0            (dip0),
        .dip1            (dip1),
        .dip2            (dip2),
        .core_reset_hold (core_reset_hold),
        .load_done       (load_done),
        .load_err        (load_err),
        .rom_bytes       (rom_bytes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   watch_hold_hi = 1'b0;
    bit   watch_hold_lo = 1'b0;
    int   hold_hi_cnt = 0;
    int   hold_lo_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor for the core ROM write port
    always @(negedge clk) begin
        exp_t e;
        if (dn_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dn_wr_spurious", 32'(dn_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("dn_addr", 32'(dn_addr), 32'(e.addr));
                chk("dn_data", 32'(dn_data), 32'(e.data));
                chk("dn_wr_latency", 32'(cyc), 32'(e.due));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk("dn_wr_missing", 32'(e.addr), 32'hFFFF_FFFF);
        end
        if (watch_hold_hi && core_reset_hold) hold_hi_cnt++;
        if (watch_hold_lo && !core_reset_hold) hold_lo_cnt++;
    end

    function automatic logic [3:0] mods();
        return {mod_bwidow, mod_gravitar, mod_lunarbat, mod_spacduel};
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dn_wr"},   32'(dn_wr), 0);
        chk({tag, "_dn_addr"}, 32'(dn_addr), 0);
        chk({tag, "_dn_data"}, 32'(dn_data), 0);
        chk({tag, "_mods"},    32'(mods()), 32'h8);
        chk({tag, "_dips"},    32'({dip0, dip1, dip2}), 0);
        chk({tag, "_hold"},    32'(core_reset_hold), 1);
        chk({tag, "_done"},    32'(load_done), 0);
        chk({tag, "_err"},     32'(load_err), 0);
        chk({tag, "_bytes"},   32'(rom_bytes), 0);
    endtask

    // Single write cycle; expect_rom pushes the expected core write
    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit expect_rom);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (expect_rom) exp_q.push_back('{a[15:0], d, cyc + 1});
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic dl_start(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic dl_end();
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drop download, then count clocks from the edge that samples the fall
    // until core_reset_hold releases. Bounded; returns -1 on timeout.
    task automatic end_rom_and_settle(output int n);
        ioctl_download = 1'b0;
        @(posedge clk);
        n = 0;
        while (core_reset_hold && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (core_reset_hold) n = -1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        #400_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", 32'(core_reset_hold), 1);

        // ROM load: 4 bytes
        dl_start(8'd0);
        for (int i = 0; i < 4; i++) wr(25'(i), 8'hA0 + 8'(i), 1'b1);
        chk("rom_bytes_4", 32'(rom_bytes), 4);
        chk("rom_hold", 32'(core_reset_hold), 1);
        end_rom_and_settle(n);
        chk("settle_clocks", 32'(n), 32'(TB_SETTLE));
        chk("load_done", 32'(load_done), 1);
        chk("rom_bytes_kept", 32'(rom_bytes), 4);

        // Overflow at the ROM_BYTES boundary
        dl_start(8'd0);
        chk("done_cleared", 32'(load_done), 0);
        chk("bytes_cleared", 32'(rom_bytes), 0);
        wr(25'd15, 8'h5F, 1'b1);
        wr(25'd16, 8'h66, 1'b0);
        chk("ovf_err", 32'(load_err), 1);
        chk("ovf_bytes", 32'(rom_bytes), 1);
        end_rom_and_settle(n);
        chk("ovf_settle", 32'(n), 32'(TB_SETTLE));
        chk("err_sticky", 32'(load_err), 1);
        dl_start(8'd0);
        chk("err_cleared", 32'(load_err), 0);

        // Settle abort: download rises again at settle clock 5
        watch_hold_lo = 1'b1;
        ioctl_download = 1'b0;
        repeat (5) @(negedge clk);
        ioctl_download = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_done", 32'(load_done), 0);
        wr(25'd3, 8'h77, 1'b1);
        chk("abort_bytes", 32'(rom_bytes), 1);
        watch_hold_lo = 1'b0;
        chk("abort_hold_lo", 32'(hold_lo_cnt), 0);
        end_rom_and_settle(n);
        chk("abort_settle", 32'(n), 32'(TB_SETTLE));
        chk("abort_load_done", 32'(load_done), 1);

        // Game-select and DIP downloads never hold the core in reset
        watch_hold_hi = 1'b1;
        dl_start(8'd1);
        wr(25'd0, 8'h02, 1'b0);
        wr(25'd3, 8'h01, 1'b0);
        dl_end();
        chk("mod_lunarbat", 32'(mods()), 32'h2);
        dl_start(8'd254);
        wr(25'd1, 8'h5A, 1'b0);
        wr(25'd5, 8'hFF, 1'b0);
        dl_end();
        chk("dip_bytes", 32'({dip0, dip1, dip2}), 32'h005A00);
        chk("dip_mod_kept", 32'(mods()), 32'h2);
        // Writes on the rise and fall cycles of the download
        ioctl_index = 8'd254;
        ioctl_download = 1'b1;
        wr(25'd2, 8'h3C, 1'b0);
        @(negedge clk);
        ioctl_download = 1'b0;
        wr(25'd0, 8'h96, 1'b0);
        repeat (2) @(negedge clk);
        chk("dip_edge_wr", 32'({dip0, dip1, dip2}), 32'h965A3C);
        watch_hold_hi = 1'b0;
        chk("mod_dip_hold", 32'(hold_hi_cnt), 0);

        // Bad mod code
        dl_start(8'd1);
        wr(25'd0, 8'h07, 1'b0);
        dl_end();
        chk("badmod_sel", 32'(mods()), 32'h8);
        chk("badmod_err", 32'(load_err), 1);

        // Unknown index: everything ignored
        dl_start(8'd5);
        wr(25'd0, 8'h11, 1'b0);
        wr(25'd1, 8'h22, 1'b0);
        dl_end();
        chk("skip_dips", 32'({dip0, dip1, dip2}), 32'h965A3C);
        chk("skip_mods", 32'(mods()), 32'h8);
        chk("skip_hold", 32'(core_reset_hold), 0);

        // Reset in the middle of a ROM download
        dl_start(8'd0);
        wr(25'd0, 8'h11, 1'b1);
        wr(25'd20, 8'h44, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wr(25'd1, 8'h22, 1'b0);
        repeat (2) @(negedge clk);
        check_reset_vals("post_rst");
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk);
        dl_start(8'd0);
        wr(25'd2, 8'h33, 1'b1);
        chk("rerun_bytes", 32'(rom_bytes), 1);
        end_rom_and_settle(n);
        chk("rerun_settle", 32'(n), 32'(TB_SETTLE));
        chk("rerun_done", 32'(load_done), 1);
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
